block_accumulator: RTL and testbench

Accumulates a block of 2^SHIFT signed ADC samples into a full-precision sum and presents it on a valid/ready output. Sits between the sample capture path and the arithmetic right-shift divider, which consumes `sum_data` to form the block average. The sum width is WIDTH+SHIFT bits, so the accumulation never overflows and the divider receives an exact sum.

---
 rtl/adc_pkg.sv | 21 ++
 rtl/sample_counter.sv | 32 +++
 rtl/block_accumulator.sv | 119 +++++++++++
 tb/tb_block_accumulator.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkg : shared types and helpers for the ADC block-averaging path. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package adc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } acc_state_t;

  // A block of 2^shift samples needs shift extra bits to stay exact.
  function automatic int sum_width(input int width, input int shift);
    return width + shift;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_counter.sv
// ---------------------------------------------------------------------------
// sample_counter : SHIFT-bit block-length counter with terminal count. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sample_counter #(
  parameter int SHIFT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [SHIFT-1:0] count,
  output logic             terminal
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + SHIFT'(1);
    end
  end

  // Terminal when count == N-1, i.e. all ones.
  assign terminal = (count == {SHIFT{1'b1}});

endmodule

`default_nettype wire

// File: rtl/block_accumulator.sv
// ---------------------------------------------------------------------------
// block_accumulator : exact sum of 2^SHIFT signed samples, valid/ready out. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module block_accumulator
  import adc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHIFT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH+SHIFT-1:0] sum_data,
  output logic                   sum_valid,
  input  logic                   sum_ready,
  output logic [SHIFT-1:0]       count,
  output logic                   busy
);

  localparam int SW = sum_width(WIDTH, SHIFT);

  acc_state_t    state;
  acc_state_t    state_next;
  logic [SW-1:0] acc;
  logic [SW-1:0] sample_ext;
  logic [SW-1:0] acc_plus;
  logic          accept;
  logic          cnt_clear;
  logic          cnt_inc;
  logic          terminal;

  assign sample_ext = {{SHIFT{in_data[WIDTH-1]}}, in_data};
  assign acc_plus   = acc + sample_ext;
  assign in_ready   = enable && (state != HOLD);
  assign accept     = in_valid && in_ready;
  assign busy       = (state != IDLE);

  sample_counter #(
    .SHIFT (SHIFT)
  ) u_sample_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .count    (count),
    .terminal (terminal)
  );

  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ACC;
          cnt_inc    = 1'b1;
        end
      end
      ACC: begin
        if (!enable) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end else if (accept) begin
          if (terminal) begin
            state_next = HOLD;
            cnt_clear  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      HOLD: begin
        // A completed sum waits for the consumer regardless of enable.
        if (sum_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_clear  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      sum_data  <= '0;
      sum_valid <= 1'b0;
    end else begin
      state     <= state_next;
      sum_valid <= (state_next == HOLD);
      if (state == IDLE) begin
        if (accept) begin
          acc <= sample_ext;
        end
      end else if (state == ACC) begin
        if (!enable) begin
          acc <= '0;
        end else if (accept) begin
          acc <= terminal ? '0 : acc_plus;
        end
      end
      if ((state == ACC) && accept && terminal) begin
        sum_data <= acc_plus;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_block_accumulator.sv
// ---------------------------------------------------------------------------
// tb_block_accumulator : scoreboard bench for block_accumulator. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_block_accumulator;

  localparam int WIDTH = 16;
  localparam int SHIFT = 4;
  localparam int N     = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   enable;
  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH+SHIFT-1:0] sum_data;
  logic                   sum_valid;
  logic                   sum_ready;
  logic [SHIFT-1:0]       count;
  logic                   busy;

  block_accumulator #(
    .WIDTH (WIDTH),
    .SHIFT (SHIFT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_data  (sum_data),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .count     (count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: samples of the open block, and whether a sum is waiting.
  logic [WIDTH+SHIFT-1:0] exp_q[$];
  longint                 blk[$];
  bit                     m_hold = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare against the
  // model, then advance the model to what the next rising edge should do.
  task automatic cyc(input logic en, input logic iv, input logic [WIDTH-1:0] d,
                     input logic sr);
    longint s;
    @(negedge clk);
    enable    = en;
    in_valid  = iv;
    in_data   = d;
    sum_ready = sr;
    #2;
    check("in_ready", longint'(in_ready), longint'(en && !m_hold));
    check("count", longint'(count), longint'(blk.size()));
    check("busy", longint'(busy), longint'(m_hold || (blk.size() != 0)));
    check("sum_valid", longint'(sum_valid), longint'(m_hold));
    if (m_hold) begin
      if (sr) m_hold = 1'b0;
    end else if ((blk.size() != 0) && !en) begin
      blk.delete();
    end else if (en && iv) begin
      blk.push_back(longint'($signed(d)));
      if (blk.size() == N) begin
        s = 0;
        foreach (blk[i]) s += blk[i];
        exp_q.push_back(s[WIDTH+SHIFT-1:0]);
        blk.delete();
        m_hold = 1'b1;
      end
    end
  endtask

  task automatic block(input logic [WIDTH-1:0] v);
    repeat (N) cyc(1'b1, 1'b1, v, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b1);
  endtask

  // Reset lands between edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("rst_sum_valid", longint'(sum_valid), 0);
    check("rst_sum_data", longint'(sum_data), 0);
    check("rst_count", longint'(count), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_in_ready", longint'(in_ready), longint'(enable));
    blk.delete();
    exp_q.delete();
    m_hold = 1'b0;
    @(negedge clk);
    reset    = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
  endtask

  // Monitor: compares whatever sum the DUT presents against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!reset && sum_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sum_unexpected: got %0h required none at %0t", sum_data, $time);
        end else begin
          check("sum_data", longint'(sum_data), longint'(exp_q[0]));
          if (sum_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    sum_ready = 1'b0;
    #1;
    check("reset_count", longint'(count), 0);
    check("reset_sum_valid", longint'(sum_valid), 0);
    check("reset_sum_data", longint'(sum_data), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_in_ready_lo", longint'(in_ready), 0);
    enable = 1'b1;
    #1;
    check("reset_in_ready_hi", longint'(in_ready), 1);
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;

    // Nominal and extremes
    block(16'd100);
    block(16'h7FFF);
    block(16'h8000);
    block(16'hFFFF);

    // Gaps: in_valid every other cycle
    for (int i = 1; i <= N; i++) begin
      cyc(1'b1, 1'b1, WIDTH'(i), 1'b1);
      cyc(1'b1, 1'b0, 16'hDEAD, 1'b1);
    end
    cyc(1'b1, 1'b0, '0, 1'b1);

    // Backpressure: samples offered during HOLD must be dropped
    repeat (N) cyc(1'b1, 1'b1, 16'd3, 1'b0);
    repeat (5) cyc(1'b1, 1'b1, 16'd9, 1'b0);
    cyc(1'b1, 1'b1, 16'd9, 1'b1);
    block(16'd4);

    // Abort after 7 samples, then a clean block
    repeat (7) cyc(1'b1, 1'b1, 16'd50, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    block(16'd2);

    // Reset mid-ACC, then reset in HOLD
    repeat (10) cyc(1'b1, 1'b1, 16'd7, 1'b1);
    do_reset();
    block(16'd5);
    repeat (N) cyc(1'b1, 1'b1, 16'd7, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    do_reset();
    block(16'd5);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 2) != 0,
          WIDTH'($urandom), $urandom_range(0, 3) != 0);
    end
    repeat (3) cyc(1'b0, 1'b0, '0, 1'b1);
    check("scoreboard_empty", longint'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
